// File: rtl/mem_port_arbiter_pkg.sv
// Shared memory-path definitions: arbiter state encoding, owner codes and default
// address/data widths used by the arbiter, memory and fetch blocks.
package riscp_mem_pkg;

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DATA_W = 32;

   localparam logic OWNER_I = 1'b0;
   localparam logic OWNER_D = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      GRANT_I,
      GRANT_D,
      DONE
   } arb_state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select for the shared memory port. Build option MEM_ARB_ROUND_ROBIN_EN
// switches tie-breaking from fixed data priority to alternating round-robin.
module mem_arb_pick (
   input  logic i_req,
   input  logic d_req,
   input  logic last_owner,
   output logic grant_d
);
   import riscp_mem_pkg::*;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   // On a tie the requester that did not hold the last grant goes first.
   assign grant_d = d_req && (!i_req || (last_owner == OWNER_I));
`else
   logic unused_last_owner;
   assign unused_last_owner = last_owner;
   assign grant_d = d_req;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch / data) arbiter for a single-port memory with registered
// memory interface and contention counter. Build option: MEM_ARB_ROUND_ROBIN_EN.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W = riscp_mem_pkg::ADDR_W,
   parameter int unsigned DATA_W = riscp_mem_pkg::DATA_W,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_ack,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              owner_d,
   output logic [CNT_W-1:0]  conflict_cnt
);
   import riscp_mem_pkg::*;

   arb_state_t        state_q, state_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              i_ack_q, i_ack_d;
   logic              d_ack_q, d_ack_d;
   logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              owner_d_q, owner_d_d;
   logic [CNT_W-1:0]  conflict_q, conflict_d;
   logic              pick_grant_d;

   // The latched owner doubles as last_owner for round-robin tie-breaking.
   mem_arb_pick u_pick (
      .i_req      (i_req),
      .d_req      (d_req),
      .last_owner (owner_d_q),
      .grant_d    (pick_grant_d)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         i_ack_q     <= 1'b0;
         d_ack_q     <= 1'b0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
         owner_d_q   <= OWNER_I;
         conflict_q  <= '0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         i_ack_q     <= i_ack_d;
         d_ack_q     <= d_ack_d;
         i_rdata_q   <= i_rdata_d;
         d_rdata_q   <= d_rdata_d;
         owner_d_q   <= owner_d_d;
         conflict_q  <= conflict_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:             if (i_req || d_req) state_d = pick_grant_d ? GRANT_D : GRANT_I;
         GRANT_I, GRANT_D: if (mem_ack) state_d = DONE;
         DONE:             state_d = IDLE;
         default:          state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      i_ack_d     = 1'b0;
      d_ack_d     = 1'b0;
      i_rdata_d   = i_rdata_q;
      d_rdata_d   = d_rdata_q;
      owner_d_d   = owner_d_q;
      conflict_d  = conflict_q;
      case (state_q)
         IDLE: begin
            if (i_req || d_req) begin
               mem_req_d = 1'b1;
               owner_d_d = pick_grant_d ? OWNER_D : OWNER_I;
               if (pick_grant_d) begin
                  mem_we_d    = d_we;
                  mem_addr_d  = d_addr;
                  mem_wdata_d = d_wdata;
               end else begin
                  mem_we_d    = 1'b0;
                  mem_addr_d  = i_addr;
                  mem_wdata_d = '0;
               end
               if (i_req && d_req && (conflict_q != '1)) conflict_d = conflict_q + CNT_W'(1);
            end
         end
         GRANT_I: begin
            if (mem_ack) begin
               mem_req_d = 1'b0;
               i_ack_d   = 1'b1;
               i_rdata_d = mem_rdata;
            end
         end
         GRANT_D: begin
            if (mem_ack) begin
               mem_req_d = 1'b0;
               d_ack_d   = 1'b1;
               if (!mem_we_q) d_rdata_d = mem_rdata;
            end
         end
         default: ;
      endcase
   end

   assign mem_req      = mem_req_q;
   assign mem_we       = mem_we_q;
   assign mem_addr     = mem_addr_q;
   assign mem_wdata    = mem_wdata_q;
   assign i_ack        = i_ack_q;
   assign d_ack        = d_ack_q;
   assign i_rdata      = i_rdata_q;
   assign d_rdata      = d_rdata_q;
   assign owner_d      = owner_d_q;
   assign conflict_cnt = conflict_q;
   assign busy         = (state_q != IDLE);

`ifndef SYNTHESIS
   // A requester must keep its request up until its access is acknowledged.
   a_i_req_held : assert property (@(posedge clk) disable iff (reset) (state_q == GRANT_I) |-> i_req);
   a_d_req_held : assert property (@(posedge clk) disable iff (reset) (state_q == GRANT_D) |-> d_req);
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: random requesters, a memory with random
// latency and stray acks, mid-access resets, checked every cycle against a latency-level model.
module tb_mem_port_arbiter;
   localparam int unsigned ADDR_W     = 16;
   localparam int unsigned DATA_W     = 32;
   localparam int unsigned CNT_W      = 3;
   localparam int unsigned CNT_MAX    = (1 << CNT_W) - 1;
   localparam int          NUM_CYCLES = 6000;

   logic              clk;
   logic              reset;
   logic              i_req, d_req, d_we;
   logic [ADDR_W-1:0] i_addr, d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              i_ack, d_ack;
   logic [DATA_W-1:0] i_rdata, d_rdata;
   logic              mem_req, mem_we, mem_ack;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata, mem_rdata;
   logic              busy, owner_d;
   logic [CNT_W-1:0]  conflict_cnt;

   mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .busy(busy), .owner_d(owner_d), .conflict_cnt(conflict_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   int          cyc = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Memory environment
   logic [DATA_W-1:0] env_mem [16];
   int                delay_cfg, wait_left, late_ack_cycle, quiet_until;
   bit                ack_sent, booting;

   // Reference model: timing is derived from the latency rules (grant at S,
   // memory busy S..S+delay, owner ack at S+delay+1, idle at S+delay+2).
   logic [DATA_W-1:0] ref_mem [16];
   bit                has_grant, g_owner_d, g_we, last_owner_d;
   int                g_start, g_delay, free_cycle;
   logic [ADDR_W-1:0] g_addr;
   logic [DATA_W-1:0] g_wdata, exp_i_rdata, exp_d_rdata;
   int unsigned       exp_cnt;

   task automatic model_step();
      bit win_d;
      if (reset) begin
         has_grant    = 1'b0;
         free_cycle   = cyc;
         g_owner_d    = 1'b0;
         g_addr       = '0;
         g_we         = 1'b0;
         g_wdata      = '0;
         exp_i_rdata  = '0;
         exp_d_rdata  = '0;
         exp_cnt      = 0;
         last_owner_d = 1'b0;
      end else begin
         if (has_grant && cyc == g_start + g_delay + 1) begin
            if (!g_owner_d)  exp_i_rdata = ref_mem[g_addr[3:0]];
            else if (g_we)   ref_mem[g_addr[3:0]] = g_wdata;
            else             exp_d_rdata = ref_mem[g_addr[3:0]];
         end
         if ((cyc - 1 >= free_cycle) && (i_req || d_req)) begin
            if (i_req && d_req) begin
               if (exp_cnt != CNT_MAX) exp_cnt++;
`ifdef MEM_ARB_ROUND_ROBIN_EN
               win_d = !last_owner_d;
`else
               win_d = 1'b1;
`endif
            end else begin
               win_d = d_req;
            end
            last_owner_d = win_d;
            has_grant    = 1'b1;
            g_start      = cyc;
            g_delay      = delay_cfg;
            g_owner_d    = win_d;
            g_addr       = win_d ? d_addr : i_addr;
            g_we         = win_d && d_we;
            g_wdata      = win_d ? d_wdata : '0;
            free_cycle   = cyc + g_delay + 2;
         end
      end
   endtask

   task automatic check_outputs();
      bit e_req, e_busy, e_iack, e_dack;
      e_req  = has_grant && cyc >= g_start && cyc <= g_start + g_delay;
      e_busy = has_grant && cyc >= g_start && cyc <= g_start + g_delay + 1;
      e_iack = has_grant && cyc == g_start + g_delay + 1 && !g_owner_d;
      e_dack = has_grant && cyc == g_start + g_delay + 1 && g_owner_d;
      chk("mem_req",      32'(mem_req),      32'(e_req));
      chk("busy",         32'(busy),         32'(e_busy));
      chk("i_ack",        32'(i_ack),        32'(e_iack));
      chk("d_ack",        32'(d_ack),        32'(e_dack));
      chk("owner_d",      32'(owner_d),      32'(g_owner_d));
      chk("mem_addr",     32'(mem_addr),     32'(g_addr));
      chk("mem_we",       32'(mem_we),       32'(g_we));
      chk("mem_wdata",    mem_wdata,         g_wdata);
      chk("i_rdata",      i_rdata,           exp_i_rdata);
      chk("d_rdata",      d_rdata,           exp_d_rdata);
      chk("conflict_cnt", 32'(conflict_cnt), exp_cnt);
   endtask

   task automatic drive();
      delay_cfg = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 6)) : int'($urandom_range(0, 1));
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      if (mem_req) begin
         if (!ack_sent) begin
            if (wait_left == 0) begin
               mem_ack   = 1'b1;
               mem_rdata = env_mem[mem_addr[3:0]];
               if (mem_we) env_mem[mem_addr[3:0]] = mem_wdata;
               ack_sent  = 1'b1;
            end else begin
               wait_left--;
            end
         end
      end else begin
         ack_sent  = 1'b0;
         wait_left = delay_cfg;
         // stray acks while the port is idle must be ignored
         if ($urandom_range(0, 5) == 0) mem_ack = 1'b1;
      end
      if (cyc == late_ack_cycle) mem_ack = 1'b1;

      if (!booting) begin
         reset = 1'b0;
         if (mem_req && !mem_ack && cyc > 50 && $urandom_range(0, 24) == 0) begin
            reset          = 1'b1;
            late_ack_cycle = cyc + 2;
            quiet_until    = cyc + 3;
         end
      end

      if (reset) begin
         i_req = 1'b0;
         d_req = 1'b0;
      end else begin
         if (i_req && i_ack) i_req = 1'b0;
         else if (!i_req && cyc >= quiet_until && $urandom_range(0, 2) == 0) begin
            i_req  = 1'b1;
            i_addr = 16'($urandom);
         end
         if (d_req && d_ack) d_req = 1'b0;
         else if (!d_req && cyc >= quiet_until && ($urandom_range(0, 2) == 0 || i_req)) begin
            d_req   = 1'b1;
            d_we    = 1'($urandom_range(0, 1));
            d_addr  = 16'($urandom);
            d_wdata = $urandom;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      model_step();
      check_outputs();
      drive();
   endtask

   initial begin
      booting        = 1'b1;
      reset          = 1'b1;
      i_req          = 1'b0;
      i_addr         = '0;
      d_req          = 1'b0;
      d_we           = 1'b0;
      d_addr         = '0;
      d_wdata        = '0;
      mem_ack        = 1'b0;
      mem_rdata      = '0;
      delay_cfg      = 0;
      wait_left      = 0;
      ack_sent       = 1'b0;
      late_ack_cycle = -1;
      quiet_until    = 0;
      has_grant      = 1'b0;
      free_cycle     = 0;
      for (int i = 0; i < 16; i++) begin
         env_mem[i] = $urandom;
         ref_mem[i] = env_mem[i];
      end
      repeat (3) tick();
      booting = 1'b0;
      reset   = 1'b0;
      repeat (NUM_CYCLES) tick();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
